clk_handshake: RTL and testbench
================================

# clk_handshake

Clock-request handshake controller on the physical-layer side of the RDI (Raw Die-to-Die Interface). When enabled, it raises `o_pl_clk_req` toward the adapter and waits for `i_lp_clk_ack`. Once the acknowledge is seen, it reports the adapter as awake. When the enable drops, it withdraws the request and waits for the acknowledge to fall. It sits between the RDI state machine, which drives `i_en` and consumes `o_adapter_is_waked_up`, and the adapter clock-gating logic.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `i_lp_clk_ack`; legal values 0–3; 0 means the acknowledge is used directly.
- `ACK_TIMEOUT`, default 1024: acknowledge wait limit in `i_clk` cycles; used only with the timeout feature.
- `i_clk`  in  1  the single clock (sideband-derived clock).
- `i_rst_n`  in  1  reset; synchronous, active-low.
- `i_en`  in  1  request the adapter clock; level.
- `i_lp_clk_ack`  in  1  adapter clock acknowledge; level.
- `o_pl_clk_req`  out  1  clock request to adapter; registered.
- `o_adapter_is_waked_up`  out  1  adapter clock is up; registered level.
- `o_timeout`  out  1  one-cycle timeout pulse; present only with `CLK_HANDSHAKE_TIMEOUT_EN`.

## Operation
The FSM has four states. `ack_s` denotes the synchronized acknowledge.
- **IDLE**: `req`=0, `wake`=0. If `i_en`=1, go to REQ. An `ack_s` that is high while in IDLE is ignored.
- **REQ**: `req`=1, `wake`=0.
  - If `i_en`=0, go to RELEASE (abort).
  - Else if `ack_s`=1, go to ACTIVE.
- **ACTIVE**: `req`=1, `wake`=1.
  - If `i_en`=0, go to RELEASE.
  - Else if `ack_s`=0 (protocol violation), go to REQ. `wake` drops and `req` stays high.
- **RELEASE**: `req`=0, `wake`=0. If `ack_s`=0, go to IDLE. `i_en` is ignored until IDLE is reached.
- When `i_en` and `ack_s` events happen in the same cycle, `i_en`=0 has priority.
- Outputs are decoded from the registered state, so there are no combinational paths from inputs to outputs.

## Timing
- During reset: state IDLE, all outputs 0, synchronizer flops and timeout counter cleared.
- `i_en` sampled high at edge N: `o_pl_clk_req`=1 after edge N+1.
- `i_lp_clk_ack` first sampled high at edge A (in REQ): `o_adapter_is_waked_up`=1 after edge A+SYNC_STAGES.
  - With `SYNC_STAGES`=0, the transition is taken at edge A itself.
- `i_en` sampled low at edge M (in ACTIVE or REQ): both outputs are 0 after edge M+1.
- In RELEASE, `i_lp_clk_ack` sampled low at edge D: IDLE after edge D+SYNC_STAGES. A new request is possible one cycle later.
- Reset asserted mid-handshake: the next edge forces IDLE and all outputs go to 0 regardless of `i_lp_clk_ack`.

## Configuration
Macro: `CLK_HANDSHAKE_TIMEOUT_EN`.
- **Defined**:
  - A counter of `$clog2(ACK_TIMEOUT+1)` bits clears on every state change and increments in REQ and RELEASE.
  - When it reaches `ACK_TIMEOUT` in REQ, go to RELEASE. When it reaches `ACK_TIMEOUT` in RELEASE, go to IDLE.
  - Either timeout pulses `o_timeout` high for one cycle.
  - The counter saturates and never wraps.
- **Undefined**: no counter and no `o_timeout` port; REQ and RELEASE wait indefinitely.

## Structure
- `clk_handshake_pkg` holds:
  - the state enum `clk_hs_state_e` (IDLE, REQ, ACTIVE, RELEASE);
  - the default constants for `SYNC_STAGES` and `ACK_TIMEOUT`.
- Sub-module `clk_handshake_sync` is a parameterized N-stage bit synchronizer with synchronous active-low reset to 0. It produces `ack_s`.
- The top level contains the FSM, the optional timeout counter and the output decode.

## Test plan
All scenarios use the default parameters.
- **Normal wake**:
  - Stimulus: `i_en`=1 after reset; ack rises 2 cycles after `req`.
  - Required: `req`=1 one cycle after `i_en`; `wake`=1 exactly 2 cycles after ack is first sampled high.
- **Release**:
  - Stimulus: in ACTIVE, drop `i_en`; drop ack 9 cycles after `req` rose.
  - Required: `req`=0 and `wake`=0 one cycle after `i_en`=0; IDLE 2 cycles after ack falls; a re-raised `i_en` is ignored until then.
- **Abort**:
  - Stimulus: `i_en` goes 1→0 while in REQ, with ack never high.
  - Required: `req` drops one cycle later; IDLE immediately after; `wake` never asserts.
- **Spurious and violation**:
  - Stimulus: ack=1 while in IDLE.
  - Required: `req` stays 0.
  - Stimulus: ack drops while in ACTIVE with `i_en`=1.
  - Required: `wake`=0 two cycles later; `req` stays 1.
- **Reset mid-ACTIVE**:
  - Stimulus: assert `i_rst_n`=0 while in ACTIVE.
  - Required: both outputs are 0 after the next edge.
- **Timeout** (with the macro defined, `ACK_TIMEOUT`=16):
  - Stimulus: `i_en`=1 with no ack.
  - Required: after 16 cycles in REQ, `o_timeout` pulses for one cycle and `req`=0.

Source files
------------

// File: rtl/clk_handshake_pkg.sv
// Shared types and default parameters for the RDI clock-request handshake controller.
package clk_handshake_pkg;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned ACK_TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } clk_hs_state_e;

endpackage

// File: rtl/clk_handshake_sync.sv
// N-stage single-bit synchronizer, synchronous active-low reset to 0; zero stages is a pass-through.
module clk_handshake_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_sync
            logic [STAGES-1:0] sync_q;
            logic [STAGES-1:0] sync_d;

            always_comb begin
                sync_d[0] = i_d;
                for (int i = 1; i < STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign o_q = sync_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/clk_handshake.sv
// PL-side RDI clock-request handshake: raises o_pl_clk_req on i_en and reports the adapter awake on ack.
// Optional acknowledge timeout enabled by defining CLK_HANDSHAKE_TIMEOUT_EN.
module clk_handshake
    import clk_handshake_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_lp_clk_ack,
    output logic o_pl_clk_req,
    output logic o_adapter_is_waked_up
`ifdef CLK_HANDSHAKE_TIMEOUT_EN
    ,
    output logic o_timeout
`endif
);

    logic          ack_s;
    clk_hs_state_e state_q, state_d;
    logic          en_q, en_d;
    logic          req_q, req_d;
    logic          wake_q, wake_d;

`ifdef CLK_HANDSHAKE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             cnt_hit;
    logic             timeout_q, timeout_d;
`endif

    clk_handshake_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_lp_clk_ack),
        .o_q     (ack_s)
    );

    // Next state, timeout counter and registered output decode; a low enable wins over ack events.
    always_comb begin
        state_d = state_q;
        en_d    = i_en;
`ifdef CLK_HANDSHAKE_TIMEOUT_EN
        timeout_d = 1'b0;
        cnt_inc   = (cnt_q == CNT_W'(ACK_TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
        cnt_hit   = (cnt_inc == CNT_W'(ACK_TIMEOUT));
`endif

        case (state_q)
            ST_IDLE: begin
                if (en_q) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!en_q) begin
                    state_d = ST_RELEASE;
                end else if (ack_s) begin
                    state_d = ST_ACTIVE;
`ifdef CLK_HANDSHAKE_TIMEOUT_EN
                end else if (cnt_hit) begin
                    state_d   = ST_RELEASE;
                    timeout_d = 1'b1;
`endif
                end
            end
            ST_ACTIVE: begin
                if (!en_q) begin
                    state_d = ST_RELEASE;
                end else if (!ack_s) begin
                    state_d = ST_REQ;
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
`ifdef CLK_HANDSHAKE_TIMEOUT_EN
                end else if (cnt_hit) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef CLK_HANDSHAKE_TIMEOUT_EN
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_REQ || state_q == ST_RELEASE) begin
            cnt_d = cnt_inc;
        end else begin
            cnt_d = cnt_q;
        end
`endif

        req_d  = (state_d == ST_REQ) || (state_d == ST_ACTIVE);
        wake_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            req_q     <= 1'b0;
            wake_q    <= 1'b0;
`ifdef CLK_HANDSHAKE_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            req_q     <= req_d;
            wake_q    <= wake_d;
`ifdef CLK_HANDSHAKE_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign o_pl_clk_req          = req_q;
    assign o_adapter_is_waked_up = wake_q;
`ifdef CLK_HANDSHAKE_TIMEOUT_EN
    assign o_timeout             = timeout_q;
`endif

endmodule

// File: tb/tb_clk_handshake.sv
// Directed bench for clk_handshake: expectations queued per step, popped and checked after each edge.
module tb_clk_handshake;

`ifdef CLK_HANDSHAKE_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 16;
`else
    localparam int unsigned TB_TIMEOUT = 1024;
`endif

    logic clk;
    logic rst_n;
    logic en;
    logic ack;
    logic req;
    logic wake;
`ifdef CLK_HANDSHAKE_TIMEOUT_EN
    logic tmo;
`endif

    typedef struct {
        string tag;
        logic  req;
        logic  wake;
        logic  tmo;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    clk_handshake #(
        .SYNC_STAGES (2),
        .ACK_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_en                  (en),
        .i_lp_clk_ack          (ack),
        .o_pl_clk_req          (req),
        .o_adapter_is_waked_up (wake)
`ifdef CLK_HANDSHAKE_TIMEOUT_EN
        ,
        .o_timeout             (tmo)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expectation, advance one edge, then pop and compare against the outputs.
    task automatic step(input string tag, input logic e_req, input logic e_wake, input logic e_tmo = 1'b0);
        exp_t       e;
        logic [2:0] obs;
        logic [2:0] expv;
        sb.push_back('{tag: tag, req: e_req, wake: e_wake, tmo: e_tmo});
        tick();
        e = sb.pop_front();
`ifdef CLK_HANDSHAKE_TIMEOUT_EN
        obs  = {req, wake, tmo};
        expv = {e.req, e.wake, e.tmo};
`else
        obs  = {req, wake, 1'b0};
        expv = {e.req, e.wake, 1'b0};
`endif
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed req/wake/tmo=%b required %b", e.tag, obs, expv);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        ack   = 1'b0;
        tick();
        tick();
        step("reset", 1'b0, 1'b0);
        rst_n = 1'b1;

        // Acknowledge high while idle is ignored.
        ack = 1'b1;
        for (int i = 0; i < 4; i++) step("spurious_ack", 1'b0, 1'b0);
        ack = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Normal wake: req two edges after en, wake two edges after ack is sampled.
        en = 1'b1;
        step("req_lat_n", 1'b0, 1'b0);
        step("req_rise", 1'b1, 1'b0);
        step("req_hold", 1'b1, 1'b0);
        ack = 1'b1;
        step("wake_lat_a", 1'b1, 1'b0);
        step("wake_lat_a1", 1'b1, 1'b0);
        step("wake_rise", 1'b1, 1'b1);

        // Ack drops while active: wake falls after the synchronizer, req stays.
        ack = 1'b0;
        step("viol_d", 1'b1, 1'b1);
        step("viol_d1", 1'b1, 1'b1);
        step("viol_wake_drop", 1'b1, 1'b0);
        ack = 1'b1;
        step("rewake_a", 1'b1, 1'b0);
        step("rewake_a1", 1'b1, 1'b0);
        step("rewake", 1'b1, 1'b1);

        // Release; a re-raised enable waits until idle is reached.
        en = 1'b0;
        step("rel_m", 1'b1, 1'b1);
        step("rel_drop", 1'b0, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 3; i++) step("rel_hold", 1'b0, 1'b0);
        ack = 1'b0;
        step("rel_d", 1'b0, 1'b0);
        step("rel_d1", 1'b0, 1'b0);
        step("rel_idle", 1'b0, 1'b0);
        step("rel_rereq", 1'b1, 1'b0);

        // Abort from REQ with no acknowledge.
        en = 1'b0;
        step("abort_m", 1'b1, 1'b0);
        step("abort_drop", 1'b0, 1'b0);
        step("abort_idle", 1'b0, 1'b0);
        en = 1'b1;
        step("abort_reen_n", 1'b0, 1'b0);
        step("abort_reen_req", 1'b1, 1'b0);

        // Reset asserted while active.
        ack = 1'b1;
        step("pre_rst_a", 1'b1, 1'b0);
        step("pre_rst_a1", 1'b1, 1'b0);
        step("pre_rst_active", 1'b1, 1'b1);
        rst_n = 1'b0;
        step("rst_mid", 1'b0, 1'b0);
        step("rst_hold", 1'b0, 1'b0);
        rst_n = 1'b1;
        step("post_rst_idle", 1'b0, 1'b0);
        step("post_rst_req", 1'b1, 1'b0);
        step("post_rst_wake", 1'b1, 1'b1);

        en  = 1'b0;
        ack = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        step("final_idle", 1'b0, 1'b0);

`ifdef CLK_HANDSHAKE_TIMEOUT_EN
        // No acknowledge: req is held for TB_TIMEOUT cycles, then a one-cycle timeout pulse.
        en = 1'b1;
        step("to_en_n", 1'b0, 1'b0);
        step("to_req", 1'b1, 1'b0);
        for (int i = 1; i < int'(TB_TIMEOUT); i++) step("to_wait", 1'b1, 1'b0);
        en = 1'b0;
        step("to_pulse", 1'b0, 1'b0, 1'b1);
        step("to_pulse_end", 1'b0, 1'b0, 1'b0);
        step("to_idle", 1'b0, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
